// File: rtl/mpadd_pkg.sv
// Shared defaults, limb-count derivation and FSM encoding for the
// limb-serial multi-precision adder.
package mpadd_pkg;

  localparam int OP_W_DEF   = 256;
  localparam int LIMB_W_DEF = 32;

  function automatic int num_limbs(input int op_w, input int limb_w);
    return op_w / limb_w;
  endfunction

  localparam int NUM_LIMBS_DEF = num_limbs(OP_W_DEF, LIMB_W_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mpadd_limb.sv
// Combinational single-limb adder with carry in and carry out.
module mpadd_limb
  import mpadd_pkg::*;
#(
  parameter int LIMB_W = LIMB_W_DEF
) (
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};

endmodule

// File: rtl/mpadd_serial.sv
// Limb-serial OP_W-bit adder: operands loaded via write/en_a/en_b, a start
// pulse runs NUM_LIMBS carry-chained limb additions, result held on s_out.
module mpadd_serial
  import mpadd_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int LIMB_W = LIMB_W_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            en_a,
  input  logic            en_b,
  input  logic            write,
  input  logic            start,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W:0]   s_out,
  output logic            ready,
  output logic            done
);

  localparam int NUM_LIMBS = num_limbs(OP_W, LIMB_W);
  localparam int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  state_t              state;
  logic [OP_W-1:0]     op_a;
  logic [OP_W-1:0]     op_b;
  logic [OP_W-1:0]     psum;
  logic [OP_W-1:0]     psum_next;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [LIMB_W-1:0]   limb_sum;
  logic                limb_cout;

  mpadd_limb #(.LIMB_W(LIMB_W)) u_limb (
    .x    (op_a[idx*LIMB_W +: LIMB_W]),
    .y    (op_b[idx*LIMB_W +: LIMB_W]),
    .cin  (carry),
    .sum  (limb_sum),
    .cout (limb_cout)
  );

  // Partial sum with the current limb merged in, so the final commit can
  // take the last limb in the same edge that stores it.
  always_comb begin
    psum_next = psum;
    psum_next[idx*LIMB_W +: LIMB_W] = limb_sum;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      s_out <= '0;
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (write && en_a) op_a <= a;
          if (write && en_b) op_b <= b;
          if (start) begin
            state <= BUSY;
            ready <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
          end
        end
        BUSY: begin
          psum  <= psum_next;
          carry <= limb_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            s_out <= {limb_cout, psum_next};
            ready <= 1'b1;
            done  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpadd_serial.sv
// Directed and randomized bench for mpadd_serial against an arithmetic model.
module tb_mpadd_serial;

  localparam int OP_W = 256;
  localparam int NL   = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic            en_a = 1'b0, en_b = 1'b0, write = 1'b0, start = 1'b0;
  logic [OP_W-1:0] a = '0, b = '0;
  logic [OP_W:0]   s_out;
  logic            ready, done;

  logic [OP_W-1:0] ma = '0, mb = '0;
  int passed = 0;
  int total  = 0;

  mpadd_serial dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en_a    (en_a),
    .en_b    (en_b),
    .write   (write),
    .start   (start),
    .a       (a),
    .b       (b),
    .s_out   (s_out),
    .ready   (ready),
    .done    (done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input logic [OP_W:0] obs, input logic [OP_W:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs; the model tracks operand writes (caller only uses this in idle).
  task automatic load(input logic wa, input logic wb, input logic [OP_W-1:0] va,
                      input logic [OP_W-1:0] vb, input logic st);
    en_a  = wa;
    en_b  = wb;
    write = wa | wb;
    a     = va;
    b     = vb;
    start = st;
    if (wa) ma = va;
    if (wb) mb = vb;
    step();
    en_a = 1'b0; en_b = 1'b0; write = 1'b0; start = 1'b0;
  endtask

  // Called right after the start edge: busy for NL cycles, then one commit.
  task automatic wait_result(input string tag);
    logic [OP_W:0] exp;
    exp = {1'b0, ma} + {1'b0, mb};
    chk({ready, done}, 2'b00, {tag, "_busy"});
    repeat (NL - 1) begin
      step();
      chk({ready, done}, 2'b00, {tag, "_busy"});
    end
    step();
    chk({ready, done}, 2'b11, {tag, "_commit"});
    chk(s_out, exp, {tag, "_sum"});
  endtask

  function automatic logic [OP_W-1:0] rnd256();
    logic [OP_W-1:0] v;
    for (int i = 0; i < OP_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [OP_W-1:0] ones;
    ones = '1;

    // 1: reset, then an empty run
    sys_rst = 1'b1;
    step(); step();
    sys_rst = 1'b0;
    chk({ready, done}, 2'b10, "rst_ctrl");
    chk(s_out, '0, "rst_sum");
    load(1'b0, 1'b0, '0, '0, 1'b1);
    wait_result("empty");
    step();
    chk({ready, done}, 2'b10, "empty_done_once");

    // 2: 1 + 1
    load(1'b1, 1'b1, 256'd1, 256'd1, 1'b0);
    load(1'b0, 1'b0, '0, '0, 1'b1);
    wait_result("one_one");
    step();
    chk({ready, done}, 2'b10, "one_one_done_once");

    // 3: full carry ripple
    load(1'b1, 1'b1, ones, 256'd1, 1'b0);
    load(1'b0, 1'b0, '0, '0, 1'b1);
    wait_result("ripple");
    chk(s_out, {1'b1, {OP_W{1'b0}}}, "ripple_const");

    // 4: max + max, written in the same cycle as start (back-to-back)
    load(1'b1, 1'b1, ones, ones, 1'b1);
    wait_result("max_max");
    chk(s_out, {1'b1, ones[OP_W-1:1], 1'b0}, "max_max_const");

    // 5: writes and start in BUSY are ignored
    step();
    load(1'b1, 1'b1, 256'd5, 256'd7, 1'b0);
    load(1'b0, 1'b0, '0, '0, 1'b1);
    step(); step(); step();
    en_a = 1'b1; write = 1'b1; a = 256'd100; start = 1'b1;
    step();
    en_a = 1'b0; write = 1'b0; start = 1'b0;
    repeat (3) begin
      chk({ready, done}, 2'b00, "lock_busy");
      step();
    end
    chk({ready, done}, 2'b00, "lock_busy");
    step();
    chk({ready, done}, 2'b11, "lock_commit");
    chk(s_out, 257'd12, "lock_sum");
    step();
    chk({ready, done}, 2'b10, "lock_done_once");
    load(1'b0, 1'b0, '0, '0, 1'b1);
    wait_result("lock_rerun");
    chk(s_out, 257'd12, "lock_rerun_const");

    // 6: reset mid-run aborts without a done pulse
    step();
    load(1'b1, 1'b1, 256'd3, 256'd4, 1'b0);
    load(1'b0, 1'b0, '0, '0, 1'b1);
    step(); step(); step(); step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    ma = '0; mb = '0;
    chk({ready, done}, 2'b10, "abort_ctrl");
    chk(s_out, '0, "abort_sum");
    repeat (NL) begin
      step();
      chk({ready, done}, 2'b10, "abort_quiet");
    end
    load(1'b1, 1'b1, 256'd3, 256'd4, 1'b1);
    wait_result("restart");
    chk(s_out, 257'd7, "restart_const");

    // randomized runs, mixing separate and same-cycle loads, single-operand updates
    for (int r = 0; r < 12; r++) begin
      logic wa, wb;
      wa = 1'($urandom_range(0, 1)) | (r < 4);
      wb = 1'($urandom_range(0, 1)) | (r < 4);
      if (r % 2 == 0) begin
        load(wa, wb, rnd256(), rnd256(), 1'b0);
        load(1'b0, 1'b0, rnd256(), rnd256(), 1'b1);
      end else begin
        load(wa, wb, rnd256(), rnd256(), 1'b1);
      end
      wait_result("rand");
    end
    step();
    chk({ready, done}, 2'b10, "final_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mpadd_serial.md
Name: mpadd_serial

Overview:
Multi-precision adder core. It is the responder side of the operand-load / start / ready protocol that the FFT benches and control logic drive.
- Two OP_W-bit operands are latched through `write` qualified by `en_a` / `en_b`.
- A `start` pulse launches a limb-serial addition that processes LIMB_W bits per cycle with a registered carry chain.
- The (OP_W+1)-bit sum appears on `s_out`, with `ready` reasserted.
- It is used for wide butterfly accumulations in the FFT datapath.

Parameters:
- OP_W, 256, operand width in bits; must be a multiple of LIMB_W.
- LIMB_W, 32, bits added per cycle.
- NUM_LIMBS, OP_W/LIMB_W (8), derived localparam; number of BUSY cycles.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- en_a  in  1  qualifies `write` to load operand A.
- en_b  in  1  qualifies `write` to load operand B.
- write  in  1  operand write strobe.
- start  in  1  single-cycle start pulse.
- a  in  OP_W  operand A data.
- b  in  OP_W  operand B data.
- s_out  out  OP_W+1  sum A+B; bit OP_W is the final carry.
- ready  out  1  high when idle; `s_out` holds the last completed result.
- done  out  1  one-cycle pulse on the edge the result is committed.

Behaviour:
- Reset (synchronous, sys_rst=1 at an edge):
  - state=IDLE, ready=1, done=0, s_out=0.
  - Operand registers A and B = 0; carry=0; limb index=0.
  - Applies regardless of current state, including mid-run: the run is aborted and no done pulse is produced.
- FSM states: IDLE, BUSY.
- Operand writes in IDLE:
  - write & en_a captures `a` into A; write & en_b captures `b` into B.
  - Both in the same cycle capture both.
  - write without en_a/en_b has no effect.
- IDLE -> BUSY: on an edge where start=1.
  - At that edge: ready<=0, limb index<=0, carry<=0.
  - A write in the same cycle as start still updates A/B at that edge, so the run uses the newly written values.
- BUSY, cycle i (i = 0..NUM_LIMBS-1):
  - Computes {c_out, sum_i} = A[i*LIMB_W +: LIMB_W] + B[i*LIMB_W +: LIMB_W] + carry.
  - Stores sum_i into the internal partial-sum register at limb i; carry<=c_out; index<=i+1.
- Completion (edge ending cycle NUM_LIMBS-1):
  - s_out <= {c_out, partial sum including limb NUM_LIMBS-1}.
  - ready<=1, done<=1 for exactly one cycle, state<=IDLE.
- Timing:
  - With start sampled at edge t0, ready is low for exactly NUM_LIMBS cycles and rises at edge t0+NUM_LIMBS.
  - done is high only during the cycle following edge t0+NUM_LIMBS.
  - Back-to-back: start may be asserted in the first ready cycle; the next run begins there.
- In BUSY:
  - start is ignored; no queueing.
  - write is ignored; A/B are locked.
  - s_out keeps the previous result until commit.
- Arithmetic: unsigned and modulo-free; s_out width OP_W+1 is never overflowed.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package mpadd_pkg holds:
  - the OP_W / LIMB_W defaults;
  - the NUM_LIMBS derivation;
  - the state encoding constants (IDLE=0, BUSY=1).
- One sub-module, mpadd_limb: combinational LIMB_W-bit adder (x, y, cin -> sum, cout), instantiated once and fed by the limb-select mux.
- FSM, index counter, carry register and result registers stay in mpadd_serial.

Test Plan:
1. Reset held 2 cycles -> ready=1, done=0, s_out=0; pulse start with no writes -> s_out=0 after 8 cycles, one done pulse.
2. Write a=1, b=1, start -> ready low exactly 8 cycles, then s_out=2, done high exactly 1 cycle.
3. a=2^256-1, b=1 -> s_out=2^256 (bit 256=1, bits 255:0=0); verifies carry propagation across all 8 limbs.
4. a=b=2^256-1 -> s_out=2^257-2; same-cycle write of a,b together with start is used by the run.
5. a=5, b=7, start; in BUSY cycle 3 assert write+en_a with a=100 and a second start -> s_out=12, single done pulse; a following start without writes again gives 12.
6. a=3, b=4, start; assert sys_rst in BUSY cycle 4 -> next cycle ready=1, s_out=0, no done pulse; restart with fresh writes a=3, b=4 -> s_out=7.
